// File: rtl/serial_gen_pkg.sv
// ---------------------------------------------------------------------------
// serial_gen_pkg
// Shared definitions for the serial pattern generator:
//   - state_t        : FSM state encoding (IDLE=0, SHIFT=1, DONE=2; 3 illegal)
//   - DEF_WIDTH      : default pattern width
//   - DEF_CNT_W      : default bit-count width
//   - clamp_len()    : maps a requested length to the number of bits sent
// ---------------------------------------------------------------------------
package serial_gen_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A zero or oversize request means "send the whole word".
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// ---------------------------------------------------------------------------
// piso_shreg
// WIDTH-bit parallel-in / serial-out shift register.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset (clears the register)
//   load    : capture data (has priority over shift)
//   shift   : advance one bit, zero-filling the vacated end
//   data    : parallel load value
//   ser_out : bit currently presented for transmission
// Build option: SERIAL_LSB_FIRST_EN defined -> bit 0 first, shifts right;
//               undefined -> bit WIDTH-1 first, shifts left.
// ---------------------------------------------------------------------------
module piso_shreg
    import serial_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             ser_out
);

    logic [WIDTH-1:0] shreg;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data register is reset so an aborted pattern can never
            // leak leftover bits after reset is released.
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
`ifdef SERIAL_LSB_FIRST_EN
            shreg <= shreg >> 1;
`else
            shreg <= shreg << 1;
`endif
        end
    end

`ifdef SERIAL_LSB_FIRST_EN
    assign ser_out = shreg[0];
`else
    assign ser_out = shreg[WIDTH-1];
`endif

endmodule

// File: rtl/serial_pattern_gen.sv
// ---------------------------------------------------------------------------
// serial_pattern_gen
// Parallel-to-serial stimulus generator. A word plus bit count is accepted
// over a valid/ready handshake in IDLE and shifted out one bit per clock,
// framed by a frame_start pulse on the first bit and a done pulse after the
// last bit.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   load_valid   : load request (only honoured in IDLE)
//   load_ready   : generator can accept a pattern
//   load_data    : pattern word (sampled on the accept edge only)
//   load_len     : bits to send; 0 or > WIDTH means WIDTH
//   x, x_valid   : serial bit and its qualifier
//   frame_start  : pulse on the first bit of a pattern
//   done         : pulse in the cycle after the last bit
//   busy         : state is not IDLE
// Build option: SERIAL_LSB_FIRST_EN selects LSB-first transmission (see
// piso_shreg); handshake and timing are identical in both builds.
// All outputs come from registers; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module serial_pattern_gen
    import serial_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_len,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ser_out;
    logic             accept;

    assign accept = (state == IDLE) && load_valid;

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (state == SHIFT),
        .data    (load_data),
        .ser_out (ser_out)
    );

    // Once a short pattern has gone out the register still holds the unsent
    // tail, so x is gated to read 0 outside SHIFT.
    assign x = x_valid & ser_out;

    // Output flags are registered alongside the state, each set to the value
    // it must have in the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            load_ready  <= 1'b1;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state       <= SHIFT;
                        cnt         <= CNT_W'(clamp_len(32'(load_len), WIDTH));
                        load_ready  <= 1'b0;
                        x_valid     <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        x_valid <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: begin
                    // Illegal encoding: fall back to a clean IDLE.
                    state      <= IDLE;
                    cnt        <= '0;
                    load_ready <= 1'b1;
                    x_valid    <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_gen
// Directed bench for serial_pattern_gen. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
// Expected bit streams are written in transmission order (first bit at
// position 7) and switch with SERIAL_LSB_FIRST_EN.
// ---------------------------------------------------------------------------
module tb_serial_pattern_gen;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic [3:0] load_len;
    logic       x;
    logic       x_valid;
    logic       frame_start;
    logic       done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    serial_pattern_gen #(.WIDTH(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_len    (load_len),
        .x           (x),
        .x_valid     (x_valid),
        .frame_start (frame_start),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".x"},          8'(x),          8'd0);
        check({tag, ".x_valid"},    8'(x_valid),    8'd0);
        check({tag, ".frame"},      8'(frame_start), 8'd0);
        check({tag, ".done"},       8'(done),       8'd0);
        check({tag, ".busy"},       8'(busy),       8'd0);
        check({tag, ".load_ready"}, 8'(load_ready), 8'd1);
    endtask

    // Load one pattern from IDLE and follow it through SHIFT, DONE and back
    // to IDLE. exp holds the expected bits in send order starting at bit 7.
    task automatic send(input string tag, input logic [7:0] data, input logic [3:0] len,
                        input logic [7:0] exp, input int n);
        check({tag, ".ready_before"}, 8'(load_ready), 8'd1);
        load_valid = 1'b1;
        load_data  = data;
        load_len   = len;
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_len   = 4'd0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.x[%0d]", tag, i), 8'(x), 8'(exp[7-i]));
            check($sformatf("%s.xv[%0d]", tag, i), 8'(x_valid), 8'd1);
            check($sformatf("%s.fs[%0d]", tag, i), 8'(frame_start), (i == 0) ? 8'd1 : 8'd0);
            check($sformatf("%s.dn[%0d]", tag, i), 8'(done), 8'd0);
            check($sformatf("%s.by[%0d]", tag, i), 8'(busy), 8'd1);
            check($sformatf("%s.rd[%0d]", tag, i), 8'(load_ready), 8'd0);
            @(negedge clk);
        end
        check({tag, ".done_pulse"}, 8'(done),       8'd1);
        check({tag, ".done_x"},     8'(x),          8'd0);
        check({tag, ".done_xv"},    8'(x_valid),    8'd0);
        check({tag, ".done_busy"},  8'(busy),       8'd1);
        check({tag, ".done_ready"}, 8'(load_ready), 8'd0);
        @(negedge clk);
        check_idle({tag, ".after"});
    endtask

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_len   = 4'd0;

        // Reset held for two cycles.
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Full 8-bit word.
`ifdef SERIAL_LSB_FIRST_EN
        send("full", 8'b1101_0010, 4'd8, 8'b0100_1011, 8);
`else
        send("full", 8'b1101_0010, 4'd8, 8'b1101_0010, 8);
`endif

        // Short 3-bit pattern.
`ifdef SERIAL_LSB_FIRST_EN
        send("short", 8'b1110_0000, 4'd3, 8'b0000_0000, 3);
`else
        send("short", 8'b1110_0000, 4'd3, 8'b1110_0000, 3);
`endif

        // Length clamping: 0 and 12 both mean 8 bits; A5 reads the same
        // in either bit order.
        send("clamp0",  8'hA5, 4'd0,  8'b1010_0101, 8);
        send("clamp12", 8'hA5, 4'd12, 8'b1010_0101, 8);

        // Handshake: valid held high through the whole first pattern with
        // the data changed mid-stream; the second pattern is taken only from
        // IDLE and carries the data present then.
        load_valid = 1'b1;
        load_data  = 8'hC3;
        load_len   = 4'd4;
        @(negedge clk);
        load_data  = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hs1.x[%0d]", i), 8'(x), (i < 2) ? 8'd1 : 8'd0);
            check($sformatf("hs1.xv[%0d]", i), 8'(x_valid), 8'd1);
            @(negedge clk);
        end
        check("hs.gap_done",  8'(done),       8'd1);
        check("hs.gap_xv0",   8'(x_valid),    8'd0);
        @(negedge clk);
        check("hs.gap_ready", 8'(load_ready), 8'd1);
        check("hs.gap_xv1",   8'(x_valid),    8'd0);
        @(negedge clk);
        load_valid = 1'b0;
        check("hs2.frame", 8'(frame_start), 8'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hs2.x[%0d]", i), 8'(x), (i < 2) ? 8'd0 : 8'd1);
            check($sformatf("hs2.xv[%0d]", i), 8'(x_valid), 8'd1);
            @(negedge clk);
        end
        check("hs2.done", 8'(done), 8'd1);
        @(negedge clk);
        check_idle("hs2.after");

        // Reset in the third bit of an 8-bit pattern takes effect at once
        // and nothing resumes afterwards.
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_len   = 4'd8;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid.xv_before", 8'(x_valid), 8'd1);
        check("mid.x_before",  8'(x),       8'd1);
        #2 rst = 1'b0;
        #1 check_idle("mid.async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid.no_resume");
        @(negedge clk);
        check_idle("mid.no_resume2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
